// File: rtl/seq_burst_arbiter.sv
// Round-robin arbiter that lends one sequence generator to two burst requesters
// and streams the captured words out over a valid/ready port tagged with the owner.
module seq_burst_arbiter #(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [LEN_W-1:0] req_len0,
  input  logic [LEN_W-1:0] req_len1,
  output logic [1:0]       grant,
  output logic [1:0]       done,
  output logic             gen_enable,
  input  logic [3:0]       gen_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_data,
  output logic             out_last,
  output logic             out_id
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q;
  logic [LEN_W-1:0] remaining_q;
  logic             fetching_q;
  logic             owner_q;
  logic             lastOwner_q;
  logic [1:0]       grant_q;
  logic [1:0]       done_q;
  logic             outValid_q;
  logic [3:0]       outData_q;
  logic             outLast_q;
  logic             outId_q;

  logic [1:0]       maskedReq;
  logic             winner_d;
  logic             finalAccept;

  // A requester finishing this cycle may not win again until its done pulse drops.
  assign maskedReq   = req & ~done_q;
  assign winner_d    = lastOwner_q ? ~maskedReq[0] : maskedReq[1];
  assign finalAccept = outValid_q && out_ready && outLast_q;

  // fetching_q stays low after the last fetch, so a full-range length never wraps.
  assign gen_enable  = (state_q == RUN) && fetching_q && (!outValid_q || out_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      fetching_q  <= 1'b0;
      owner_q     <= 1'b0;
      lastOwner_q <= 1'b1;
      grant_q     <= '0;
      done_q      <= '0;
      outValid_q  <= 1'b0;
      outData_q   <= '0;
      outLast_q   <= 1'b0;
      outId_q     <= 1'b0;
    end else begin
      done_q <= '0;
      case (state_q)
        IDLE: begin
          if (|maskedReq) begin
            state_q     <= RUN;
            remaining_q <= winner_d ? req_len1 : req_len0;
            fetching_q  <= 1'b1;
            owner_q     <= winner_d;
            lastOwner_q <= winner_d;
            grant_q     <= winner_d ? 2'b10 : 2'b01;
          end
        end
        RUN: begin
          if (gen_enable) begin
            outData_q  <= gen_data;
            outValid_q <= 1'b1;
            outId_q    <= owner_q;
            outLast_q  <= (remaining_q == '0);
            if (remaining_q == '0) begin
              fetching_q <= 1'b0;
            end else begin
              remaining_q <= remaining_q - LEN_W'(1);
            end
          end else if (outValid_q && out_ready) begin
            outValid_q <= 1'b0;
          end
          if (finalAccept) begin
            state_q    <= IDLE;
            done_q     <= owner_q ? 2'b10 : 2'b01;
            grant_q    <= '0;
            outValid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant     = grant_q;
  assign done      = done_q;
  assign out_valid = outValid_q;
  assign out_data  = outData_q;
  assign out_last  = outLast_q;
  assign out_id    = outId_q;

endmodule

// File: tb/tb_seq_burst_arbiter.sv
// Directed bench for seq_burst_arbiter with a behavioural generator cycling
// A,B,E,7,F,2,0,D that is never reset, matching the real generator.
module tb_seq_burst_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] req;
  logic [3:0] req_len0;
  logic [3:0] req_len1;
  logic [1:0] grant;
  logic [1:0] done;
  logic       gen_enable;
  logic [3:0] gen_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       out_last;
  logic       out_id;

  int checks = 0;
  int failures = 0;
  int enCount = 0;
  int enStart;
  logic [2:0] genIdx = 3'd0;
  logic [3:0] expWords [16];

  seq_burst_arbiter #(.LEN_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_len0  (req_len0),
    .req_len1  (req_len1),
    .grant     (grant),
    .done      (done),
    .gen_enable(gen_enable),
    .gen_data  (gen_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_id    (out_id)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] seqVal(input logic [2:0] idx);
    case (idx)
      3'd0: return 4'hA;
      3'd1: return 4'hB;
      3'd2: return 4'hE;
      3'd3: return 4'h7;
      3'd4: return 4'hF;
      3'd5: return 4'h2;
      3'd6: return 4'h0;
      default: return 4'hD;
    endcase
  endfunction

  assign gen_data = seqVal(genIdx);

  always @(posedge clk) begin
    if (gen_enable) begin
      genIdx  <= genIdx + 3'd1;
      enCount <= enCount + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic [3:0] l0, input logic [3:0] l1,
                               input logic rdy);
    req       = r;
    req_len0  = l0;
    req_len1  = l1;
    out_ready = rdy;
  endtask

  // Words are listed most-significant nibble first.
  task automatic loadWords(input logic [63:0] v);
    for (int i = 0; i < 16; i++) expWords[i] = v[63-4*i -: 4];
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " grant"}, 32'(grant), 32'h0);
    checkOutput({tag, " done"}, 32'(done), 32'h0);
    checkOutput({tag, " gen_enable"}, 32'(gen_enable), 32'h0);
    checkOutput({tag, " out_valid"}, 32'(out_valid), 32'h0);
    checkOutput({tag, " out_last"}, 32'(out_last), 32'h0);
    checkOutput({tag, " out_id"}, 32'(out_id), 32'h0);
    checkOutput({tag, " out_data"}, 32'(out_data), 32'h0);
  endtask

  // Called on a falling edge; returns on the falling edge that shows the n-th word.
  task automatic collectWords(input string tag, input int n, input logic expId, input logic checkLast);
    int w;
    for (int i = 0; i < n; i++) begin
      w = 0;
      if (i > 0) @(negedge clk);
      while (!out_valid && w < 20) begin
        @(negedge clk);
        w++;
      end
      checkOutput($sformatf("%s valid[%0d]", tag, i), 32'(out_valid), 32'h1);
      if (!out_valid) return;
      if (i > 0) checkOutput($sformatf("%s gap[%0d]", tag, i), 32'(w), 32'h0);
      checkOutput($sformatf("%s data[%0d]", tag, i), 32'(out_data), 32'(expWords[i]));
      checkOutput($sformatf("%s id[%0d]", tag, i), 32'(out_id), 32'(expId));
      checkOutput($sformatf("%s grant[%0d]", tag, i), 32'(grant), expId ? 32'h2 : 32'h1);
      checkOutput($sformatf("%s last[%0d]", tag, i), 32'(out_last),
                  32'(checkLast && (i == n - 1)));
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    applyStimulus(2'b00, 4'd0, 4'd0, 1'b1);
    @(negedge clk);
    checkResetState("reset");
    @(negedge clk);
    reset = 1'b0;

    // Single burst of three words from requester 0.
    applyStimulus(2'b01, 4'd2, 4'd0, 1'b1);
    @(negedge clk);
    checkOutput("t1 grant", 32'(grant), 32'h1);
    checkOutput("t1 first valid", 32'(out_valid), 32'h0);
    checkOutput("t1 first enable", 32'(gen_enable), 32'h1);
    loadWords(64'hABE0_0000_0000_0000);
    collectWords("t1", 3, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("t1 done", 32'(done), 32'h1);
    checkOutput("t1 grant idle", 32'(grant), 32'h0);
    checkOutput("t1 valid idle", 32'(out_valid), 32'h0);

    // Eight words for requester 1, granted on the done cycle's closing edge.
    applyStimulus(2'b10, 4'd0, 4'd7, 1'b1);
    enStart = enCount;
    @(negedge clk);
    checkOutput("t2 grant", 32'(grant), 32'h2);
    loadWords(64'h7F20_DABE_0000_0000);
    collectWords("t2", 8, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("t2 done", 32'(done), 32'h2);
    checkOutput("t2 enable count", 32'(enCount - enStart), 32'd8);
    applyStimulus(2'b00, 4'd0, 4'd0, 1'b1);

    // Contention with both requests held after a fresh reset.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkResetState("t3 reset");
    reset = 1'b0;
    applyStimulus(2'b11, 4'd0, 4'd0, 1'b1);
    loadWords(64'h7000_0000_0000_0000);
    collectWords("t3 b0", 1, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("t3 done0", 32'(done), 32'h1);
    loadWords(64'hF000_0000_0000_0000);
    collectWords("t3 b1", 1, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("t3 done1", 32'(done), 32'h2);
    loadWords(64'h2000_0000_0000_0000);
    collectWords("t3 b2", 1, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("t3 done2", 32'(done), 32'h1);
    loadWords(64'h0000_0000_0000_0000);
    collectWords("t3 b3", 1, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("t3 done3", 32'(done), 32'h2);
    applyStimulus(2'b00, 4'd0, 4'd0, 1'b1);
    @(negedge clk);

    // Backpressure: ready low for three cycles after the first word.
    applyStimulus(2'b01, 4'd3, 4'd0, 1'b1);
    loadWords(64'hD000_0000_0000_0000);
    collectWords("t4 head", 1, 1'b0, 1'b0);
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checkOutput($sformatf("t4 stall enable[%0d]", c), 32'(gen_enable), 32'h0);
      checkOutput($sformatf("t4 stall data[%0d]", c), 32'(out_data), 32'hD);
      checkOutput($sformatf("t4 stall valid[%0d]", c), 32'(out_valid), 32'h1);
      @(negedge clk);
    end
    checkOutput("t4 held data", 32'(out_data), 32'hD);
    out_ready = 1'b1;
    @(negedge clk);
    loadWords(64'hABE0_0000_0000_0000);
    collectWords("t4 tail", 3, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("t4 done", 32'(done), 32'h1);
    applyStimulus(2'b00, 4'd0, 4'd0, 1'b1);
    @(negedge clk);

    // Reset asserted between edges after two of eight words.
    applyStimulus(2'b01, 4'd7, 4'd0, 1'b1);
    loadWords(64'h7F00_0000_0000_0000);
    collectWords("t5 pre", 2, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    checkResetState("t5 async reset");
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(2'b01, 4'd0, 4'd0, 1'b1);
    loadWords(64'h2000_0000_0000_0000);
    collectWords("t5 post", 1, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("t5 done", 32'(done), 32'h1);
    applyStimulus(2'b00, 4'd0, 4'd0, 1'b1);
    @(negedge clk);

    // Maximum length: sixteen words, a single done pulse.
    applyStimulus(2'b01, 4'd15, 4'd0, 1'b1);
    loadWords(64'h0DAB_E7F2_0DAB_E7F2);
    collectWords("t6", 16, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("t6 done", 32'(done), 32'h1);
    applyStimulus(2'b00, 4'd0, 4'd0, 1'b1);
    @(negedge clk);
    checkOutput("t6 done pulse width", 32'(done), 32'h0);
    checkOutput("t6 grant idle", 32'(grant), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
